// File: rtl/seq_detector_param_pkg.sv
// Shared defaults and FSM encoding for the serial sequence detector.
// Holds default pattern width/value, counter width and detector state enum.
package seq_detector_param_pkg;

  localparam int DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk, rst (async active-low), inc, clr (sync), q, sat (q all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector: pulses F when the last PATTERN_W valid bits equal pattern.
// Ports: clk, rst (async low), x_valid, x, pat_load, pat_in, overlap, F, match_cnt, cnt_sat.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_valid,
  input  logic                 x,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
  input  logic                 overlap,
  output logic                 F,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat
);

  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);

  logic [PATTERN_W-1:0] pattern, pattern_n;
  logic [PATTERN_W-1:0] hist, hist_n, hist_sh;
  logic [FW-1:0]        fill, fill_n, fill_inc;
  det_state_e           state, state_n;
  logic                 f_n;
  logic                 match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= PATTERN;
      hist    <= '0;
      fill    <= '0;
      state   <= FILLING;
      F       <= 1'b0;
    end else begin
      pattern <= pattern_n;
      hist    <= hist_n;
      fill    <= fill_n;
      state   <= state_n;
      F       <= f_n;
    end
  end

  // Once ARMED the window is full, so fill saturates.
  assign hist_sh  = {hist[PATTERN_W-2:0], x};
  assign fill_inc = (state == ARMED) ? fill : fill + FW'(1);

  always_comb begin
    pattern_n = pattern;
    hist_n    = hist;
    fill_n    = fill;
    f_n       = 1'b0;
    match     = 1'b0;
    unique case (1'b1)
      pat_load: begin
        pattern_n = pat_in;
        hist_n    = '0;
        fill_n    = '0;
      end
      x_valid && !pat_load: begin
        hist_n = hist_sh;
        match  = (fill_inc == FULL) && (hist_sh == pattern);
        f_n    = match;
        // Non-overlapping: demand a full fresh window.
        fill_n = (match && !overlap) ? '0 : fill_inc;
      end
      default: ;
    endcase
    state_n = (fill_n == FULL) ? ARMED : FILLING;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (1'b0),
    .q   (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed streams, queued expectations.
// Two DUTs share stimulus: default widths, and CNT_W=3 for saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, rst3;
  logic       x_valid, x, pat_load, overlap;
  logic [3:0] pat_in;

  logic       f0, sat0;
  logic [7:0] cnt0;
  logic       f3, sat3;
  logic [2:0] cnt3;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x         (x),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .F         (f0),
    .match_cnt (cnt0),
    .cnt_sat   (sat0)
  );

  seq_detector_param #(
    .CNT_W(3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .x_valid   (x_valid),
    .x         (x),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .F         (f3),
    .match_cnt (cnt3),
    .cnt_sat   (sat3)
  );

  typedef struct packed {
    logic        sel;
    logic        f;
    logic [7:0]  cnt;
    logic        sat;
    logic [15:0] id;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  int         step_id = 0;
  logic       cur_sel = 1'b0;
  logic [7:0] ecnt0 = 8'd0;
  logic [7:0] ecnt3 = 8'd0;

  task automatic check(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got F/cnt/sat=%h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares after every active edge for which an expectation exists.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.sel == 1'b0)
        check($sformatf("step%0d_dut", e.id), {f0, cnt0, sat0},
              {e.f, e.cnt, e.sat});
      else
        check($sformatf("step%0d_dut3", e.id), {f3, 5'd0, cnt3, sat3},
              {e.f, e.cnt, e.sat});
    end
  end

  // Called at a negedge; drives one edge's inputs and queues its expectation.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [3:0] pi, input logic ef);
    exp_t e;
    x_valid  = v;
    x        = b;
    pat_load = ld;
    pat_in   = pi;
    step_id++;
    if (cur_sel == 1'b0) begin
      if (ef && ecnt0 != 8'hFF) ecnt0++;
      e = '{1'b0, ef, ecnt0, ecnt0 == 8'hFF, 16'(step_id)};
    end else begin
      if (ef && ecnt3 != 8'd7) ecnt3++;
      e = '{1'b1, ef, ecnt3, ecnt3 == 8'd7, 16'(step_id)};
    end
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_bits(input logic [15:0] bits, input logic [15:0] efs,
                          input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 4'h0, efs[i]);
  endtask

  initial begin
    int k;
    rst      = 1'b0;
    rst3     = 1'b0;
    x_valid  = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'h0;
    overlap  = 1'b1;
    @(negedge clk);

    // Held in reset while x toggles.
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 4'h0, 1'b0);
    rst = 1'b1;

    // Overlapping, default pattern 1011.
    run_bits(16'b1011011, 16'b0001001, 7);
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);

    // Non-overlapping.
    overlap = 1'b0;
    run_bits(16'b1011011, 16'b0001000, 7);
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    overlap = 1'b1;

    // Idle cycles with garbage x between valid bits.
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);

    // Pattern reload discards stale bits; x ignored on the load edge.
    run_bits(16'b10, 16'b00, 2);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    run_bits(16'b0110, 16'b0001, 4);

    // Saturation on the 3-bit counter instance.
    check("dut3_held_in_reset", {f3, 5'd0, cnt3, sat3}, 10'd0);
    rst     = 1'b0;
    rst3    = 1'b1;
    cur_sel = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    run_bits(16'hFFF, 16'b0000_1111_1111_1, 12);
    check("dut_reset_during_t6", {f0, cnt0, sat0}, 10'd0);

    // Async reset between edges clears outputs immediately.
    #2;
    rst3 = 1'b0;
    #1;
    check("dut3_async_reset", {f3, 5'd0, cnt3, sat3}, 10'd0);

    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
